// File: rtl/cmp_search_if.sv
// Operand/flag bundle between cmp_search and the magnitude comparator.
// The err line exists only when CMP_SEARCH_FLAG_CHECK_EN is defined.
interface cmp_search_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] guess;
  logic             eq;
  logic             big_a;
  logic             big_b;
  logic             busy;
  logic             done;
  logic             found;
  logic [WIDTH-1:0] result;
  logic [WIDTH-1:0] steps;
`ifdef CMP_SEARCH_FLAG_CHECK_EN
  logic             err;
`endif

  modport master (
    input  start, eq, big_a, big_b,
    output guess, busy, done, found, result, steps
`ifdef CMP_SEARCH_FLAG_CHECK_EN
    , output err
`endif
  );

  modport slave (
    output start, eq, big_a, big_b,
    input  guess, busy, done, found, result, steps
`ifdef CMP_SEARCH_FLAG_CHECK_EN
    , input err
`endif
  );
endinterface

// File: rtl/cmp_search.sv
// Binary-search controller driving a magnitude comparator to locate a hidden operand.
// Optional macro CMP_SEARCH_FLAG_CHECK_EN adds an err output for non-one-hot comparator flags.
module cmp_search #(
  parameter int WIDTH = 8
) (
  input logic          clk,
  input logic          rst,
  cmp_search_if.master bus
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_SAMPLE = 2'd2;
  localparam logic [1:0] S_DONE   = 2'd3;

  localparam logic signed [WIDTH+1:0] ONE_S = (WIDTH+2)'(1);

  logic [1:0]       state;
  logic [WIDTH:0]   lo;
  logic [WIDTH:0]   hi;
  logic [WIDTH-1:0] guess_r;
  logic [WIDTH-1:0] result_r;
  logic [WIDTH-1:0] steps_r;
  logic             found_r;

  // Floor midpoint of [lo, hi]; only called while lo <= hi, so the sum stays in range.
  function automatic logic [WIDTH-1:0] midpoint(input logic [WIDTH:0] l, input logic [WIDTH:0] h);
    logic [WIDTH:0] span;
    logic [WIDTH:0] mid;
    span = h - l;
    mid  = l + (span >> 1);
    return mid[WIDTH-1:0];
  endfunction

  // Bound updates are evaluated one bit wider and signed so hi = -1 and lo = 2^WIDTH compare correctly.
  logic signed [WIDTH+1:0] guess_s;
  logic signed [WIDTH+1:0] lo_s;
  logic signed [WIDTH+1:0] hi_s;
  logic signed [WIDTH+1:0] new_lo;
  logic signed [WIDTH+1:0] new_hi;
  logic                    take_a;
  logic                    exhausted;

  always_comb begin
    guess_s   = {2'b00, guess_r};
    lo_s      = {1'b0, lo};
    hi_s      = {1'b0, hi};
    take_a    = bus.big_a;
    new_lo    = take_a ? lo_s : (guess_s + ONE_S);
    new_hi    = take_a ? (guess_s - ONE_S) : hi_s;
    exhausted = (new_lo > new_hi);
  end

`ifdef CMP_SEARCH_FLAG_CHECK_EN
  logic err_r;
  logic flag_fault;

  always_comb begin
    flag_fault = !(({bus.eq, bus.big_a, bus.big_b} == 3'b100) ||
                   ({bus.eq, bus.big_a, bus.big_b} == 3'b010) ||
                   ({bus.eq, bus.big_a, bus.big_b} == 3'b001));
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      lo       <= '0;
      hi       <= '0;
      guess_r  <= '0;
      result_r <= '0;
      steps_r  <= '0;
      found_r  <= 1'b0;
`ifdef CMP_SEARCH_FLAG_CHECK_EN
      err_r    <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            lo       <= '0;
            hi       <= {1'b0, {WIDTH{1'b1}}};
            steps_r  <= '0;
            found_r  <= 1'b0;
            result_r <= '0;
`ifdef CMP_SEARCH_FLAG_CHECK_EN
            err_r    <= 1'b0;
`endif
            state    <= S_CALC;
          end
        end

        S_CALC: begin
          guess_r <= midpoint(lo, hi);
          steps_r <= steps_r + 1'b1;
          state   <= S_SAMPLE;
        end

        // Comparator is combinational: flags reflect guess_r, which is stable this cycle.
        S_SAMPLE: begin
`ifdef CMP_SEARCH_FLAG_CHECK_EN
          if (flag_fault) begin
            err_r    <= 1'b1;
            found_r  <= 1'b0;
            result_r <= '0;
            state    <= S_DONE;
          end else
`endif
          if (bus.eq) begin
            found_r  <= 1'b1;
            result_r <= guess_r;
            state    <= S_DONE;
          end else begin
            lo <= new_lo[WIDTH:0];
            hi <= new_hi[WIDTH:0];
            if (exhausted) begin
              found_r <= 1'b0;
              state   <= S_DONE;
            end else begin
              state <= S_CALC;
            end
          end
        end

        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.guess  = guess_r;
  assign bus.busy   = (state != S_IDLE);
  assign bus.done   = (state == S_DONE);
  assign bus.found  = found_r;
  assign bus.result = result_r;
  assign bus.steps  = steps_r;
`ifdef CMP_SEARCH_FLAG_CHECK_EN
  assign bus.err    = err_r;
`endif

endmodule

// File: tb/tb_cmp_search.sv
// Self-checking bench for cmp_search: comparator modelled around a hidden target,
// results checked against a plain-integer binary-search reference.
module tb_cmp_search;
  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cmp_search_if #(.WIDTH(W)) bus ();
  cmp_search #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.master));

  int checks = 0;
  int errors = 0;
  int tgt    = 0;
  int mode   = 0;   // 0 honest comparator, 1 stuck big_b, 2 eq+big_a together

  always_comb begin
    bus.eq    = 1'b0;
    bus.big_a = 1'b0;
    bus.big_b = 1'b0;
    case (mode)
      0: begin
        bus.eq    = (int'(bus.guess) == tgt);
        bus.big_a = (int'(bus.guess) >  tgt);
        bus.big_b = (int'(bus.guess) <  tgt);
      end
      1: bus.big_b = 1'b1;
      default: begin
        bus.eq    = 1'b1;
        bus.big_a = 1'b1;
      end
    endcase
  end

  // Reference model outputs
  int exp_guesses[$];
  int exp_found, exp_result, exp_steps, exp_err;

  function automatic void model(input int t, input int m);
    int lo, hi, g, e, a, b;
    lo = 0; hi = (1 << W) - 1;
    exp_guesses.delete();
    exp_found = 0; exp_result = 0; exp_steps = 0; exp_err = 0;
    while (exp_steps < 64) begin
      g = lo + (hi - lo) / 2;
      exp_guesses.push_back(g);
      exp_steps++;
      if (m == 0) begin e = (g == t); a = (g > t); b = (g < t); end
      else if (m == 1) begin e = 0; a = 0; b = 1; end
      else begin e = 1; a = 1; b = 0; end
`ifdef CMP_SEARCH_FLAG_CHECK_EN
      if (e + a + b != 1) begin exp_err = 1; exp_found = 0; exp_result = 0; break; end
`endif
      if (e != 0) begin exp_found = 1; exp_result = g; break; end
      else if (a != 0) hi = g - 1;
      else lo = g + 1;
      if (lo > hi) begin exp_found = 0; break; end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one search; restart_k>0 pulses start again for one cycle k ticks after launch.
  task automatic run_search(input string name, input int t, input int m, input int restart_k);
    int got_guesses[$];
    int done_k, busy_cnt;
    bit seq_ok;
    tgt = t; mode = m;
    model(t, m);
    bus.start = 1'b1;
    done_k = -1; busy_cnt = 0;
    for (int k = 1; k <= 60; k++) begin
      tick();
      bus.start = (k == restart_k);
      if (bus.done === 1'b1) begin done_k = k; break; end
      if (bus.busy === 1'b1) busy_cnt++;
      if (k % 2 == 0) got_guesses.push_back(int'(bus.guess));
    end
    checks++;
    if (done_k != 2 * exp_steps + 1) begin
      errors++;
      $display("FAIL %s done_cycle: got %0d required %0d", name, done_k, 2 * exp_steps + 1);
    end
    if (done_k < 0) begin
      bus.start = 1'b0;
      return;
    end
    checks++;
    if (busy_cnt != 2 * exp_steps) begin
      errors++;
      $display("FAIL %s busy_cycles: got %0d required %0d", name, busy_cnt, 2 * exp_steps);
    end
    checks++;
    if (bus.found !== exp_found[0]) begin
      errors++;
      $display("FAIL %s found: got %b required %0d", name, bus.found, exp_found);
    end
    checks++;
    if (int'(bus.result) != exp_result) begin
      errors++;
      $display("FAIL %s result: got %0h required %0h", name, bus.result, exp_result);
    end
    checks++;
    if (int'(bus.steps) != exp_steps) begin
      errors++;
      $display("FAIL %s steps: got %0d required %0d", name, bus.steps, exp_steps);
    end
    seq_ok = (got_guesses.size() == exp_guesses.size());
    if (seq_ok)
      foreach (exp_guesses[i]) if (got_guesses[i] != exp_guesses[i]) seq_ok = 0;
    checks++;
    if (!seq_ok) begin
      errors++;
      $display("FAIL %s guess_seq: got %0d probes required %0d (first got %0h required %0h)", name,
               got_guesses.size(), exp_guesses.size(),
               (got_guesses.size() > 0) ? got_guesses[0] : -1, exp_guesses[0]);
    end
`ifdef CMP_SEARCH_FLAG_CHECK_EN
    checks++;
    if (bus.err !== exp_err[0]) begin
      errors++;
      $display("FAIL %s err: got %b required %0d", name, bus.err, exp_err);
    end
`endif
    tick();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || int'(bus.result) != exp_result) begin
      errors++;
      $display("FAIL %s after_done: got done=%b busy=%b result=%0h required 0 0 %0h", name,
               bus.done, bus.busy, bus.result, exp_result);
    end
  endtask

  task automatic check_idle_cleared(input string name);
    checks++;
    if (bus.guess !== '0 || bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.found !== 1'b0 ||
        bus.result !== '0 || bus.steps !== '0) begin
      errors++;
      $display("FAIL %s: got guess=%0h busy=%b done=%b found=%b result=%0h steps=%0d required all 0",
               name, bus.guess, bus.busy, bus.done, bus.found, bus.result, bus.steps);
    end
`ifdef CMP_SEARCH_FLAG_CHECK_EN
    checks++;
    if (bus.err !== 1'b0) begin
      errors++;
      $display("FAIL %s err: got %b required 0", name, bus.err);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.start = 1'b0; mode = 0; tgt = 0;
    tick(); tick();
    rst = 1'b0;
    tick();
    check_idle_cleared("reset_state");
  endtask

  task automatic test_boundaries();
    run_search("first_hit_7f", 8'h7F, 0, 0);
    run_search("target_ff", 8'hFF, 0, 0);
    run_search("target_00", 8'h00, 0, 0);
    run_search("stuck_big_b", 8'h00, 1, 0);
  endtask

  task automatic test_flag_priority();
    run_search("eq_and_big_a", 8'h33, 2, 0);
    run_search("after_fault", 8'hA5, 0, 0);
  endtask

  task automatic test_restart_ignored();
    run_search("restart_k3", 8'h40, 0, 3);
    run_search("restart_k6", 8'h40, 0, 6);
  endtask

  task automatic test_random();
    for (int i = 0; i < 12; i++)
      run_search("random", int'($urandom_range(0, (1 << W) - 1)), 0, 0);
  endtask

  task automatic test_start_in_done();
    tgt = 8'h7F; mode = 0;
    bus.start = 1'b1; tick();
    bus.start = 1'b0; tick(); tick();
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL start_in_done setup: got done=%b required 1", bus.done);
    end
    bus.start = 1'b1; tick();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done ignored: got busy=%b required 0", bus.busy);
    end
    tick();
    checks++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL start_in_done idle: got busy=%b done=%b required 0 0", bus.busy, bus.done);
    end
  endtask

  task automatic test_reset_mid();
    bit seen_done;
    bit reached;
    tgt = 8'h10; mode = 0;
    reached = 0;
    bus.start = 1'b1; tick();
    bus.start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      if (int'(bus.steps) == 3) begin reached = 1; break; end
      tick();
    end
    checks++;
    if (!reached) begin
      errors++;
      $display("FAIL reset_mid reach_step3: got steps=%0d required 3", bus.steps);
    end
    rst = 1'b1; tick();
    rst = 1'b0;
    check_idle_cleared("reset_mid_cleared");
    seen_done = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (bus.done === 1'b1 || bus.busy === 1'b1) seen_done = 1;
    end
    checks++;
    if (seen_done) begin
      errors++;
      $display("FAIL reset_mid no_done: got activity after reset required none");
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    test_reset();
    test_boundaries();
    test_flag_priority();
    test_restart_ignored();
    test_start_in_done();
    test_random();
    test_reset_mid();
    run_search("post_reset", 8'hC3, 0, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmp_search.md
Name: cmp_search

Overview:
- Sequential binary-search controller that sits on the operand side of the team's magnitude comparator.
- Drives candidate operand `guess` into comparator input `a`. The comparator's other input `b` carries an unknown target value.
- Consumes the comparator's `eq`/`big_a`/`big_b` flags and converges on the target.
- Reports the target value, a found flag and the probe count.

Parameters:
- WIDTH, 8, operand width in bits; WIDTH >= 2. Search range is 0 .. 2^WIDTH-1.

Ports:
- clk     input   1      system clock, rising edge
- rst     input   1      synchronous reset, active-high
- start   input   1      begin new search; sampled only in IDLE
- guess   output  WIDTH  candidate operand, drives comparator input a
- eq      input   1      comparator: guess == target
- big_a   input   1      comparator: guess > target
- big_b   input   1      comparator: guess < target
- busy    output  1      high in every state except IDLE
- done    output  1      one-cycle pulse when search ends
- found   output  1      target located; valid from done, held until next start
- result  output  WIDTH  located value; valid from done, held until next start
- steps   output  WIDTH  probes issued in last search; held until next start

Behaviour:
- One clock domain; reset is synchronous and active-high. All state is registered.
- Reset values: guess=0, busy=0, done=0, found=0, result=0, steps=0, state=IDLE.
- Internal lo/hi registers are WIDTH+1 bits wide, so hi may reach -1 and lo may reach 2^WIDTH with no wrap.
- FSM states: IDLE, CALC, SAMPLE, DONE.
- IDLE:
  - busy=0.
  - On start=1: lo<=0, hi<=2^WIDTH-1, steps<=0, found<=0, result<=0; go to CALC.
- CALC:
  - guess <= lo + ((hi-lo)>>1), i.e. floor midpoint.
  - steps <= steps+1.
  - Go to SAMPLE.
- SAMPLE:
  - The comparator is combinational; flags are sampled this cycle against the stable guess.
  - Priority: eq > big_a > big_b. No flag asserted is treated as big_b.
  - eq: found<=1, result<=guess; go to DONE.
  - big_a: hi <= guess-1.
  - big_b: lo <= guess+1.
  - After an update: if new lo > new hi, found<=0 and go to DONE; otherwise go to CALC.
- DONE: done=1 for exactly one cycle; go to IDLE.
- Timing:
  - Each probe costs 2 cycles.
  - A first-probe hit asserts done in the 3rd cycle after start is sampled.
  - Worst case is WIDTH+1 probes.
- start while busy is ignored. start asserted in the DONE cycle is also ignored, because it is sampled only in IDLE.
- rst mid-search forces IDLE on the next edge and clears all outputs; no done pulse is generated.
- guess holds its last value in IDLE and DONE.

Optional Feature:
- Macro: CMP_SEARCH_FLAG_CHECK_EN.
- Defined:
  - Extra output port `err` (1 bit). Reset value 0; cleared on start.
  - In SAMPLE, if {eq,big_a,big_b} is not exactly one-hot: err<=1, found<=0, result<=0, go to DONE.
  - steps includes the faulty probe.
- Undefined:
  - No err port.
  - Priority rule above applies to any flag combination.

Test Plan (WIDTH=8; bench models the comparator with hidden target T):
- T=0x7F, pulse start -> single probe guess=0x7F; done in 3rd cycle after start; found=1, result=0x7F, steps=1.
- T=0xFF -> guesses 7F,BF,DF,EF,F7,FB,FD,FE,FF; found=1, result=0xFF, steps=9; busy high for 18 cycles.
- T=0x00 -> guesses 7F,3F,1F,0F,07,03,01,00; found=1, result=0x00, steps=8; no hi underflow.
- Comparator stuck with only big_b=1 -> walks up to 0xFF, then lo=0x100 > hi; found=0, steps=9, done pulses once.
- start re-pulsed during search for T=0x40 -> ignored; result=0x40. rst asserted at step 3 of a new search -> next cycle busy=0, steps=0, no done pulse.
- With CMP_SEARCH_FLAG_CHECK_EN: eq=1 and big_a=1 on first probe -> err=1, found=0, steps=1. Next start clears err.
